// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// small decode helpers used by the top level and the byte-lane datapath.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        ST_RD = 2'b10,
        ST_WR = 2'b11
    } state_e;

    // Byte and half stores need a read-modify-write; word and reserved do not.
    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SIZE_B) || (size == SIZE_H);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == SIZE_B) return 1'b0;
        if (size == SIZE_H) return addr_lo[0];
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane datapath: big-endian load extraction with sign or
// zero extension, and the store merge used by byte/half read-modify-write.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        load_data  = rd;
        merge_data = wdata;
        case (size)
            SIZE_B: begin
                load_data  = {{24{~is_unsigned & rd[31]}}, rd[31:24]};
                merge_data = {wdata[7:0], rd[23:0]};
            end
            SIZE_H: begin
                load_data  = {{16{~is_unsigned & rd[31]}}, rd[31:16]};
                merge_data = {wdata[15:0], rd[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the MEM stage and a big-endian data
// memory. Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
    output logic                      busy,
    output logic                      resp_valid,
    output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
    output logic                      misalign_err,
    output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
    output logic                      mem_write_en,
    input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

    state_e                    state, state_next;
    logic [ADDR_BUS_WIDTH-1:0] addr_q;
    logic [DATA_BUS_WIDTH-1:0] wdata_q;
    logic [1:0]                size_q;
    logic                      unsigned_q;
    logic                      write_q;
    logic [DATA_BUS_WIDTH-1:0] wr_q;
    logic [DATA_BUS_WIDTH-1:0] rdata_q;
    logic                      resp_q;
    logic                      misalign_q;
    logic [DATA_BUS_WIDTH-1:0] load_data;
    logic [DATA_BUS_WIDTH-1:0] merge_data;
    logic                      accept;
    logic                      trap;

    assign accept = (state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_byte_lane u_byte_lane (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rd          (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_comb begin
        state_next     = state;
        mem_addr       = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                if (accept && !trap) begin
                    if (!req_write)                 state_next = LOAD;
                    else if (is_sub_word(req_size)) state_next = ST_RD;
                    else                            state_next = ST_WR;
                end
            end
            LOAD:  begin mem_addr = addr_q; state_next = IDLE;  end
            ST_RD: begin mem_addr = addr_q; state_next = ST_WR; end
            ST_WR: begin
                mem_addr       = addr_q;
                mem_write_en   = 1'b1;
                mem_write_data = wr_q;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            wr_q       <= '0;
            rdata_q    <= '0;
            resp_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_next;
            resp_q     <= (state == LOAD) || (state == ST_WR);
            misalign_q <= accept && trap;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                write_q    <= req_write;
                if (req_write && !is_sub_word(req_size)) wr_q <= req_wdata;
            end
            if (state == ST_RD) wr_q <= merge_data;
            // Store responses leave the last load result untouched.
            if (state == LOAD && !write_q) rdata_q <= load_data;
        end
    end

    assign busy         = (state != IDLE);
    assign resp_valid   = resp_q;
    assign resp_rdata   = rdata_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// traffic against a byte-addressed reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid, misalign_err, mem_write_en;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] last_rdata;

    load_store_unit #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .misalign_err   (misalign_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Big-endian data memory seen by the DUT.
    always_comb begin
        logic [7:0] a;
        a = mem_addr[7:0];
        mem_read_data = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr[7:0]]         <= mem_write_data[31:24];
            mem[mem_addr[7:0] + 8'd1]  <= mem_write_data[23:16];
            mem[mem_addr[7:0] + 8'd2]  <= mem_write_data[15:8];
            mem[mem_addr[7:0] + 8'd3]  <= mem_write_data[7:0];
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: byte-level memory semantics.
    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [7:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_mem[a];
        h = {ref_mem[a], ref_mem[a + 8'd1]};
        case (sz)
            2'd0:    return uns ? 32'(b) : 32'($signed(b));
            2'd1:    return uns ? 32'(h) : 32'($signed(h));
            default: return ref_word(a);
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        case (sz)
            2'd0: ref_mem[a] = wd[7:0];
            2'd1: begin ref_mem[a] = wd[15:8]; ref_mem[a + 8'd1] = wd[7:0]; end
            default: begin
                ref_mem[a]        = wd[31:24];
                ref_mem[a + 8'd1] = wd[23:16];
                ref_mem[a + 8'd2] = wd[15:8];
                ref_mem[a + 8'd3] = wd[7:0];
            end
        endcase
    endtask

    function automatic logic ref_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd1) return a[0];
        if (sz >= 2'd2) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[a + 8'(i)]     = w[31 - 8*i -: 8];
            ref_mem[a + 8'(i)] = w[31 - 8*i -: 8];
        end
    endtask

    // One transaction, observed for four cycles after acceptance (T+1..T+4).
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        trap, sub;
        int          exp_wr_k, exp_resp_k, exp_mis_k;
        logic [31:0] exp_rdata, exp_wdata;
        int          resp_k, resp_n, wr_k, wr_n, mis_k, mis_n;
        logic [31:0] wdata_obs, waddr_obs;
        logic [4:1]  busy_obs, busy_exp;

        trap       = ref_trap(sz, addr);
        sub        = wr && (sz <= 2'd1);
        exp_wr_k   = (trap || !wr) ? 0 : (sub ? 2 : 1);
        exp_resp_k = trap ? 0 : (!wr ? 2 : (sub ? 3 : 2));
        exp_mis_k  = trap ? 1 : 0;
        exp_rdata  = last_rdata;
        exp_wdata  = 32'h0;
        if (!trap && !wr) exp_rdata = ref_load(sz, uns, addr[7:0]);
        if (!trap && wr) begin
            ref_store(sz, addr[7:0], wd);
            exp_wdata = ref_word(addr[7:0]);
        end
        for (int k = 1; k <= 4; k++) busy_exp[k] = (k < exp_resp_k);

        resp_k = 0; resp_n = 0; wr_k = 0; wr_n = 0; mis_k = 0; mis_n = 0;
        wdata_obs = 32'h0; waddr_obs = 32'h0; busy_obs = '0;

        @(negedge clk);
        check({tag, " idle_before"}, 32'(busy), 32'h0);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            busy_obs[k] = busy;
            if (resp_valid)   begin resp_k = k; resp_n++; end
            if (misalign_err) begin mis_k = k;  mis_n++;  end
            if (mem_write_en) begin
                wr_k = k; wr_n++; wdata_obs = mem_write_data; waddr_obs = mem_addr;
            end
        end

        check({tag, " resp_cycle"}, 32'(resp_k), 32'(exp_resp_k));
        check({tag, " resp_count"}, 32'(resp_n), (exp_resp_k != 0) ? 32'd1 : 32'd0);
        check({tag, " write_cycle"}, 32'(wr_k), 32'(exp_wr_k));
        check({tag, " write_count"}, 32'(wr_n), (exp_wr_k != 0) ? 32'd1 : 32'd0);
        check({tag, " misalign_cycle"}, 32'(mis_k), 32'(exp_mis_k));
        check({tag, " misalign_count"}, 32'(mis_n), 32'(exp_mis_k));
        check({tag, " busy_profile"}, 32'(busy_obs), 32'(busy_exp));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        if (exp_wr_k != 0) begin
            check({tag, " write_data"}, wdata_obs, exp_wdata);
            check({tag, " write_addr"}, waddr_obs, addr);
        end
        last_rdata = exp_rdata;
    endtask

    initial begin
        int wr_before;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        last_rdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        set_word(8'h04, 32'h3333_3333);
        set_word(8'h08, 32'hAAAA_AAAA);
        set_word(8'h0C, 32'hCCCC_CCCC);

        @(posedge clk); #1;
        check("reset busy", 32'(busy), 32'h0);
        check("reset resp_valid", 32'(resp_valid), 32'h0);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset write_en", 32'(mem_write_en), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        do_req("ld_w_0x4",  1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        do_req("ld_b_s_0x8", 1'b0, 2'd0, 1'b0, 32'h8, 32'h0);
        do_req("ld_b_u_0x8", 1'b0, 2'd0, 1'b1, 32'h8, 32'h0);
        do_req("st_h_0xC",  1'b1, 2'd1, 1'b0, 32'hC, 32'h0000_1234);
        do_req("st_w_0x10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req("ld_w_0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req("ld_w_0x6",  1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        do_req("ld_rsv_0x14", 1'b0, 2'd3, 1'b0, 32'h14, 32'h0);

        // Reset asserted while a byte store sits in its read phase.
        @(negedge clk);
        wr_before = wr_count;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid busy_in_st_rd", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy), 32'h0);
        check("rst_mid mem_addr", mem_addr, 32'h0);
        check("rst_mid write_en", 32'(mem_write_en), 32'h0);
        @(posedge clk); #1;
        check("rst_mid resp_valid", 32'(resp_valid), 32'h0);
        check("rst_mid rdata", resp_rdata, 32'h0);
        check("rst_mid misalign", 32'(misalign_err), 32'h0);
        check("rst_mid write_data", mem_write_data, 32'h0);
        check("rst_mid write_en_next", 32'(mem_write_en), 32'h0);
        check("rst_mid no_write", 32'(wr_count - wr_before), 32'h0);
        check("rst_mid mem_byte", 32'(mem[8'h20]), 32'(ref_mem[8'h20]));
        last_rdata = 32'h0;
        @(negedge clk) rst_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_req($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) check($sformatf("final mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
        check("final write_en_idle", 32'(mem_write_en), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
